seg7_capture: RTL and testbench

//   Receive-side companion to the dice/7-segment driver: samples a 7-segment + DP bus
//   (segment bit order {g,f,e,d,c,b,a}, active-high) and debounces it until stable.

---
 rtl/seg7_capture.sv | 126 ++++++++++++
 tb/tb_seg7_capture.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_capture.sv
// Debounces a sampled 7-segment + DP bus, decodes each newly stable pattern to a digit
// and queues the reports in a small first-word-fall-through FIFO behind a valid/ready port.
module seg7_capture #(
    parameter int STABLE_CYCLES = 1024,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic [6:0] seg_in,
    input  logic       dp_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_digit,
    output logic       out_dp,
    output logic       out_invalid,
    output logic       overflow,
    output logic       stable
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [PTR_W:0]   DEPTH   = (PTR_W + 1)'(FIFO_DEPTH);

    // Entry layout: {invalid, dp, digit[3:0]}
    function automatic logic [5:0] decode(input logic [7:0] pat);
        logic [3:0] digit;
        logic       invalid;
        invalid = 1'b0;
        case (pat[6:0])
            7'h3F:        digit = 4'd0;
            7'h06:        digit = 4'd1;
            7'h5B:        digit = 4'd2;
            7'h4F:        digit = 4'd3;
            7'h66:        digit = 4'd4;
            7'h6D:        digit = 4'd5;
            7'h7C, 7'h7D: digit = 4'd6;
            7'h07, 7'h27: digit = 4'd7;
            7'h7F:        digit = 4'd8;
            7'h6F, 7'h67: digit = 4'd9;
            7'h00:        digit = 4'hF;
            default: begin
                digit   = 4'hF;
                invalid = 1'b1;
            end
        endcase
        return {invalid, pat[7], digit};
    endfunction

    logic [7:0]       sync1_p0, sync2_p1;
    logic [7:0]       cur_p2, last_p2;
    logic             last_vld;
    logic [CNT_W-1:0] cnt;
    logic [5:0]       mem [FIFO_DEPTH];
    logic [5:0]       hold_q, head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             report, push, pop, full, wr_en;

    assign report = (sync2_p1 == cur_p2) && (cnt == CNT_MAX) && !stable;
    assign push   = report && (!last_vld || (cur_p2 != last_p2));
    assign full   = (count == DEPTH);
    assign pop    = out_valid && out_ready;
    // A push into a full FIFO still lands when the head leaves on the same edge
    assign wr_en  = push && (!full || pop);

    assign out_valid   = (count != '0);
    assign head        = out_valid ? mem[rd_ptr] : hold_q;
    assign out_digit   = head[3:0];
    assign out_dp      = head[4];
    assign out_invalid = head[5];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync1_p0 <= '0;
            sync2_p1 <= '0;
            cur_p2   <= '0;
            last_p2  <= '0;
            last_vld <= 1'b0;
            cnt      <= '0;
            stable   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            hold_q   <= '0;
        end else begin
            // Stage p0/p1: two-flop synchroniser
            sync1_p0 <= {dp_in, seg_in};
            sync2_p1 <= sync1_p0;
            // Stage p2: stability tracking and report generation
            if (sync2_p1 != cur_p2) begin
                cur_p2 <= sync2_p1;
                cnt    <= '0;
                stable <= 1'b0;
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                stable <= 1'b1;
            end
            if (report) begin
                last_p2  <= cur_p2;
                last_vld <= 1'b1;
            end
            if (push && !wr_en)
                overflow <= 1'b1;
            if (wr_en)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
            if (out_valid)
                hold_q <= mem[rd_ptr];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wr_en)
            mem[wr_ptr] <= decode(cur_p2);
    end

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture with STABLE_CYCLES=4, FIFO_DEPTH=4.
module tb_seg7_capture;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i = 1'b1;
    logic [6:0] seg_in   = 7'h00;
    logic       dp_in    = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_digit;
    logic       out_dp;
    logic       out_invalid;
    logic       overflow;
    logic       stable;

    int errors = 0;
    int checks = 0;

    seg7_capture #(.STABLE_CYCLES(4), .FIFO_DEPTH(4)) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .seg_in     (seg_in),
        .dp_in      (dp_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_digit  (out_digit),
        .out_dp     (out_dp),
        .out_invalid(out_invalid),
        .overflow   (overflow),
        .stable     (stable)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic tick(input int n);
        repeat (n) @(posedge wb_clk_i);
        #1;
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
    endtask

    task automatic hold_pattern(input logic [6:0] seg, input logic dp, input int n);
        seg_in = seg;
        dp_in  = dp;
        tick(n);
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        seg_in   = 7'h06;
        dp_in    = 1'b0;
        tick(2);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (out_digit !== 4'd0) begin errors++; $display("FAIL reset_digit got=%h exp=0", out_digit); end
        checks++; if (out_dp !== 1'b0) begin errors++; $display("FAIL reset_dp got=%b exp=0", out_dp); end
        checks++; if (out_invalid !== 1'b0) begin errors++; $display("FAIL reset_invalid got=%b exp=0", out_invalid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (stable !== 1'b0) begin errors++; $display("FAIL reset_stable got=%b exp=0", stable); end
    endtask

    // Pattern 06 present as reset releases: first edge after release samples it.
    task automatic test_latency();
        int k;
        wb_rst_i = 1'b0;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (out_valid) begin k = i; break; end
        end
        checks++; if (k != 7) begin errors++; $display("FAIL latency_edges got=%0d exp=7", k); end
        checks++; if (out_digit !== 4'd1) begin errors++; $display("FAIL latency_digit got=%h exp=1", out_digit); end
        checks++; if (out_dp !== 1'b0) begin errors++; $display("FAIL latency_dp got=%b exp=0", out_dp); end
        checks++; if (out_invalid !== 1'b0) begin errors++; $display("FAIL latency_invalid got=%b exp=0", out_invalid); end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL latency_stable got=%b exp=1", stable); end
        pop_one();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL latency_pop_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_glitch();
        hold_pattern(7'h6D, 1'b0, 12);
        hold_pattern(7'h7F, 1'b0, 3);
        hold_pattern(7'h6D, 1'b0, 12);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL glitch_valid got=%b exp=1", out_valid); end
        checks++; if (out_digit !== 4'd5) begin errors++; $display("FAIL glitch_digit got=%h exp=5", out_digit); end
        pop_one();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL glitch_single_report got_valid=%b exp=0", out_valid); end
    endtask

    task automatic test_decode();
        logic [6:0] pats [6];
        logic       dps  [6];
        logic [3:0] exp_d[6];
        logic       exp_i[6];
        int         n_rep;
        logic [3:0] got_d;
        logic       got_i, got_p;
        pats  = '{7'h3F, 7'h4F, 7'h7C, 7'h27, 7'h00, 7'h49};
        dps   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_d = '{4'd0, 4'd3, 4'd6, 4'd7, 4'hF, 4'hF};
        exp_i = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int p = 0; p < 6; p++) begin
            seg_in = pats[p];
            dp_in  = dps[p];
            n_rep  = 0;
            got_d  = 4'h0;
            got_i  = 1'b0;
            got_p  = 1'b0;
            for (int c = 0; c < 20; c++) begin
                tick(1);
                if (out_valid) begin
                    n_rep++;
                    got_d = out_digit;
                    got_i = out_invalid;
                    got_p = out_dp;
                end
            end
            checks++; if (n_rep != 1) begin errors++; $display("FAIL decode_count[%0d] got=%0d exp=1", p, n_rep); end
            checks++; if (got_d !== exp_d[p]) begin errors++; $display("FAIL decode_digit[%0d] got=%h exp=%h", p, got_d, exp_d[p]); end
            checks++; if (got_i !== exp_i[p]) begin errors++; $display("FAIL decode_invalid[%0d] got=%b exp=%b", p, got_i, exp_i[p]); end
            checks++; if (got_p !== dps[p]) begin errors++; $display("FAIL decode_dp[%0d] got=%b exp=%b", p, got_p, dps[p]); end
        end
        out_ready = 1'b0;
        dp_in = 1'b0;
    endtask

    task automatic test_overflow();
        logic [6:0] pats [5];
        logic [3:0] exp_d[4];
        pats  = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D};
        exp_d = '{4'd1, 4'd2, 4'd3, 4'd4};
        for (int p = 0; p < 5; p++) hold_pattern(pats[p], 1'b0, 12);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        for (int p = 0; p < 4; p++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid[%0d] got=%b exp=1", p, out_valid); end
            checks++; if (out_digit !== exp_d[p]) begin errors++; $display("FAIL ovf_digit[%0d] got=%h exp=%h", p, out_digit, exp_d[p]); end
            pop_one();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got=%b exp=0", out_valid); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_reset_mid();
        int k;
        hold_pattern(7'h7F, 1'b0, 12);
        hold_pattern(7'h6F, 1'b0, 12);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid got=%b exp=1", out_valid); end
        wb_rst_i = 1'b1;
        tick(1);
        wb_rst_i = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_overflow got=%b exp=0", overflow); end
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (out_valid) begin k = i; break; end
        end
        checks++; if (k != 7) begin errors++; $display("FAIL rstmid_latency got=%0d exp=7", k); end
        checks++; if (out_digit !== 4'd9) begin errors++; $display("FAIL rstmid_digit got=%h exp=9", out_digit); end
        pop_one();
        tick(20);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_single got=%b exp=0", out_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid_ovf_after got=%b exp=0", overflow); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] pats [4];
        logic [3:0] exp_d[4];
        pats  = '{7'h3F, 7'h06, 7'h5B, 7'h4F};
        exp_d = '{4'd1, 4'd2, 4'd3, 4'd4};
        for (int p = 0; p < 4; p++) hold_pattern(pats[p], 1'b0, 12);
        seg_in = 7'h66;
        tick(6);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow got=%b exp=0", overflow); end
        for (int p = 0; p < 4; p++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got=%b exp=1", p, out_valid); end
            checks++; if (out_digit !== exp_d[p]) begin errors++; $display("FAIL b2b_digit[%0d] got=%h exp=%h", p, out_digit, exp_d[p]); end
            pop_one();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got=%b exp=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_decode();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
